// File: rtl/rv_if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_if_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Fetch targets are always word aligned; low address bits are discarded.
   function automatic logic [31:0] alignPc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_out_reg.sv
// One-entry output slot between fetch and decode; flush beats load beats consume.
module if_out_reg
   import rv_if_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        consume_i,
   input  logic        flush_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (load_i) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end else if (consume_i && valid_q) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= 32'h0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem requests, redirect handling.
module if_stage
   import rv_if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  fetchPc_q, fetchPc_d;
   logic [31:0]  redirTarget;
   logic         slotFree;
   logic         loadOut;

   assign slotFree    = !if_valid || id_ready;
   assign imem_req    = (state_q == FETCH) && slotFree && !rst;
   assign imem_addr   = pc_q;
   assign redirTarget = alignPc(redirect_pc);

   // A redirect always wins the PC; any response still owed by memory is
   // swallowed in DRAIN so only one request is ever outstanding.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fetchPc_d = fetchPc_q;
      loadOut   = 1'b0;
      case (state_q)
         FETCH: begin
            if (imem_req && imem_gnt) begin
               if (redirect_valid) begin
                  pc_d    = redirTarget;
                  state_d = DRAIN;
               end else begin
                  fetchPc_d = pc_q;
                  pc_d      = pc_q + 32'd4;
                  state_d   = WAIT;
               end
            end else if (redirect_valid) begin
               pc_d = redirTarget;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_d    = redirTarget;
               state_d = imem_rvalid ? FETCH : DRAIN;
            end else if (imem_rvalid) begin
               loadOut = 1'b1;
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (redirect_valid) begin
               pc_d = redirTarget;
            end
            if (imem_rvalid) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         fetchPc_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         fetchPc_q <= fetchPc_d;
      end
   end

   if_out_reg u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load_i    (loadOut),
      .consume_i (id_ready),
      .flush_i   (redirect_valid),
      .instr_i   (imem_rdata),
      .pc_i      (fetchPc_q),
      .valid_o   (if_valid),
      .instr_o   (if_instr),
      .pc_o      (if_pc)
   );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scenario tasks plus a transaction-level fetch model.
module tb_if_stage;
   import rv_if_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   int nChecks = 0;
   int nPass   = 0;

   // Per-cycle controls set by the scenarios
   bit          ctlRst = 1'b1;
   bit          ctlReady = 1'b1;
   bit          ctlRedir = 1'b0;
   logic [31:0] ctlRedirPc = 32'h0;
   int          gntMode = 1;
   int          latLo = 1;
   int          latHi = 1;
   bit          spurious = 1'b0;

   // Memory side
   bit          memPend = 1'b0;
   int          memDue = 0;
   logic [31:0] memAddr = 32'h0;
   int          cyc = 0;

   // Reference model: expected next fetch address, outstanding fetch, output slot
   logic [31:0] mNext = RST_PC;
   bit          mOut = 1'b0;
   bit          mDiscard = 1'b0;
   logic [31:0] mOutPc = 32'h0;
   bit          mValid = 1'b0;
   logic [31:0] mPc = 32'h0;
   logic [31:0] mInstr = NOP_INSTR;

   bit          lastReq;
   logic [31:0] lastAddr;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
   endfunction

   task automatic modelReset();
      mNext    = RST_PC;
      mOut     = 1'b0;
      mDiscard = 1'b0;
      mValid   = 1'b0;
      mPc      = 32'h0;
      mInstr   = NOP_INSTR;
      memPend  = 1'b0;
   endtask

   // Drives one clock cycle, plays memory, steps the model and compares.
   task automatic applyStimulus();
      bit expReq;
      bit grant;
      bit rv;
      rst            = ctlRst;
      id_ready       = ctlReady;
      redirect_valid = ctlRedir;
      redirect_pc    = ctlRedirPc;
      if (memPend && cyc >= memDue) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memWord(memAddr);
         memPend     = 1'b0;
      end else if (!memPend && spurious && $urandom_range(9) == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = $urandom;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      case (gntMode)
         0:       imem_gnt = 1'b0;
         1:       imem_gnt = 1'b1;
         default: imem_gnt = 1'($urandom_range(1));
      endcase
      #1;
      lastReq  = imem_req;
      lastAddr = imem_addr;
      expReq   = ctlRst ? 1'b0 : (!mOut && (!mValid || ctlReady));
      nChecks++;
      if (imem_req !== expReq)
         $display("[TB] FAIL req cyc=%0d actual=%b expected=%b", cyc, imem_req, expReq);
      else
         nPass++;
      if (expReq && imem_req === 1'b1) begin
         nChecks++;
         if (imem_addr !== mNext)
            $display("[TB] FAIL addr cyc=%0d actual=%h expected=%h", cyc, imem_addr, mNext);
         else
            nPass++;
      end
      if (imem_req === 1'b1 && imem_gnt && !memPend && !ctlRst) begin
         memPend = 1'b1;
         memAddr = imem_addr;
         memDue  = cyc + int'($urandom_range(latHi, latLo));
      end
      if (ctlRst) begin
         modelReset();
      end else begin
         grant = expReq && imem_gnt;
         rv    = imem_rvalid && mOut;
         if (ctlRedir) begin
            mValid = 1'b0;
            mInstr = NOP_INSTR;
         end else if (rv && !mDiscard) begin
            mValid = 1'b1;
            mPc    = mOutPc;
            mInstr = memWord(mOutPc);
         end else if (ctlReady && mValid) begin
            mValid = 1'b0;
            mInstr = NOP_INSTR;
         end
         if (rv) mOut = 1'b0;
         if (grant) begin
            mOut     = 1'b1;
            mOutPc   = mNext;
            mDiscard = ctlRedir;
         end else if (ctlRedir && mOut) begin
            mDiscard = 1'b1;
         end
         if (ctlRedir)   mNext = {ctlRedirPc[31:2], 2'b00};
         else if (grant) mNext = mNext + 32'd4;
      end
      @(posedge clk);
      #1;
      cyc = ctlRst ? 0 : cyc + 1;
      nChecks++;
      if (if_valid !== mValid)
         $display("[TB] FAIL valid cyc=%0d actual=%b expected=%b", cyc, if_valid, mValid);
      else
         nPass++;
      nChecks++;
      if (if_instr !== mInstr)
         $display("[TB] FAIL instr cyc=%0d actual=%h expected=%h", cyc, if_instr, mInstr);
      else
         nPass++;
      if (mValid) begin
         nChecks++;
         if (if_pc !== mPc)
            $display("[TB] FAIL pc cyc=%0d actual=%h expected=%h", cyc, if_pc, mPc);
         else
            nPass++;
      end
   endtask

   task automatic test_reset();
      ctlRst = 1'b1; ctlReady = 1'b1; ctlRedir = 1'b0;
      gntMode = 1; latLo = 1; latHi = 1; spurious = 1'b0;
      applyStimulus();
      applyStimulus();
      nChecks++;
      if (if_valid !== 1'b0 || if_instr !== NOP_INSTR || if_pc !== 32'h0)
         $display("[TB] FAIL reset_out actual=%b/%h/%h expected=0/%h/0",
                  if_valid, if_instr, if_pc, NOP_INSTR);
      else
         nPass++;
      nChecks++;
      if (lastReq !== 1'b0)
         $display("[TB] FAIL reset_req actual=%b expected=0", lastReq);
      else
         nPass++;
      ctlRst = 1'b0;
   endtask

   task automatic test_stream();
      for (int k = 0; k < 8; k++) begin
         applyStimulus();
         if (k == 0) begin
            nChecks++;
            if (lastReq !== 1'b1 || lastAddr !== RST_PC)
               $display("[TB] FAIL first_fetch actual=%b/%h expected=1/%h", lastReq, lastAddr, RST_PC);
            else
               nPass++;
         end else if (k % 2 == 1) begin
            nChecks++;
            if (if_valid !== 1'b1 || if_pc !== RST_PC + 32'(4 * ((k - 1) / 2)))
               $display("[TB] FAIL stream_pc k=%0d actual=%b/%h expected=1/%h",
                        k, if_valid, if_pc, RST_PC + 32'(4 * ((k - 1) / 2)));
            else
               nPass++;
         end else begin
            nChecks++;
            if (if_valid !== 1'b0)
               $display("[TB] FAIL stream_gap k=%0d actual=%b expected=0", k, if_valid);
            else
               nPass++;
         end
      end
   endtask

   task automatic test_stall();
      ctlReady = 1'b0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus();
         nChecks++;
         if (lastReq !== 1'b0 || if_valid !== 1'b1 || if_pc !== RST_PC + 32'hC
             || if_instr !== memWord(RST_PC + 32'hC))
            $display("[TB] FAIL stall k=%0d actual=%b/%b/%h/%h expected=0/1/%h/%h", k,
                     lastReq, if_valid, if_pc, if_instr, RST_PC + 32'hC, memWord(RST_PC + 32'hC));
         else
            nPass++;
      end
      ctlReady = 1'b1;
      applyStimulus();
      nChecks++;
      if (lastReq !== 1'b1 || lastAddr !== RST_PC + 32'h10)
         $display("[TB] FAIL stall_release actual=%b/%h expected=1/%h", lastReq, lastAddr, RST_PC + 32'h10);
      else
         nPass++;
   endtask

   task automatic test_redirect_on_grant();
      bit seen;
      ctlRst = 1'b1; applyStimulus(); ctlRst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (!mOut && (!mValid || ctlReady) && mNext == RST_PC + 32'h4) seen = 1'b1;
         else applyStimulus();
      end
      ctlRedir = 1'b1; ctlRedirPc = 32'h200;
      applyStimulus();
      ctlRedir = 1'b0;
      nChecks++;
      if (!seen || lastReq !== 1'b1 || lastAddr !== RST_PC + 32'h4)
         $display("[TB] FAIL redir_grant_req actual=%b/%h expected=1/%h", lastReq, lastAddr, RST_PC + 32'h4);
      else
         nPass++;
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         applyStimulus();
         if (if_valid === 1'b1) seen = 1'b1;
      end
      nChecks++;
      if (!seen || if_pc !== 32'h200)
         $display("[TB] FAIL redir_grant_next actual=%b/%h expected=1/00000200", seen, if_pc);
      else
         nPass++;
   endtask

   task automatic test_redirect_in_wait();
      bit seen;
      ctlRst = 1'b1; applyStimulus(); ctlRst = 1'b0;
      latLo = 4; latHi = 4;
      applyStimulus();
      ctlRedir = 1'b1; ctlRedirPc = 32'h300;
      applyStimulus();
      ctlRedir = 1'b0;
      latLo = 1; latHi = 1;
      nChecks++;
      if (if_valid !== 1'b0 || lastReq !== 1'b0)
         $display("[TB] FAIL redir_wait_flush actual=%b/%b expected=0/0", if_valid, lastReq);
      else
         nPass++;
      seen = 1'b0;
      for (int k = 0; k < 15 && !seen; k++) begin
         applyStimulus();
         if (if_valid === 1'b1) seen = 1'b1;
      end
      nChecks++;
      if (!seen || if_pc !== 32'h300 || if_instr !== memWord(32'h300))
         $display("[TB] FAIL redir_wait_next actual=%b/%h/%h expected=1/00000300/%h",
                  seen, if_pc, if_instr, memWord(32'h300));
      else
         nPass++;
   endtask

   task automatic test_wrap();
      logic [31:0] got [2];
      int n;
      ctlRedir = 1'b1; ctlRedirPc = 32'hFFFF_FFFE;
      applyStimulus();
      ctlRedir = 1'b0;
      n = 0;
      for (int k = 0; k < 20 && n < 2; k++) begin
         applyStimulus();
         if (if_valid === 1'b1) begin
            got[n] = if_pc;
            n++;
         end
      end
      nChecks++;
      if (n < 1 || got[0] !== 32'hFFFF_FFFC)
         $display("[TB] FAIL wrap_first count=%0d actual=%h expected=fffffffc", n, got[0]);
      else
         nPass++;
      nChecks++;
      if (n < 2 || got[1] !== 32'h0)
         $display("[TB] FAIL wrap_second count=%0d actual=%h expected=00000000", n, got[1]);
      else
         nPass++;
   endtask

   task automatic test_reset_mid();
      latLo = 3; latHi = 3;
      for (int k = 0; k < 10 && !mOut; k++) applyStimulus();
      ctlRst = 1'b1;
      applyStimulus();
      ctlRst = 1'b0;
      nChecks++;
      if (if_valid !== 1'b0 || if_instr !== NOP_INSTR || if_pc !== 32'h0)
         $display("[TB] FAIL rst_wait actual=%b/%h/%h expected=0/%h/0", if_valid, if_instr, if_pc, NOP_INSTR);
      else
         nPass++;
      applyStimulus();
      nChecks++;
      if (lastReq !== 1'b1 || lastAddr !== RST_PC)
         $display("[TB] FAIL rst_wait_refetch actual=%b/%h expected=1/%h", lastReq, lastAddr, RST_PC);
      else
         nPass++;
      ctlReady = 1'b0;
      for (int k = 0; k < 10 && !mValid; k++) applyStimulus();
      ctlRst = 1'b1;
      applyStimulus();
      ctlRst = 1'b0;
      ctlReady = 1'b1;
      latLo = 1; latHi = 1;
      nChecks++;
      if (if_valid !== 1'b0 || if_instr !== NOP_INSTR)
         $display("[TB] FAIL rst_valid actual=%b/%h expected=0/%h", if_valid, if_instr, NOP_INSTR);
      else
         nPass++;
   endtask

   task automatic test_random();
      gntMode = 2; latLo = 1; latHi = 3; spurious = 1'b1;
      for (int k = 0; k < 800; k++) begin
         ctlReady   = ($urandom_range(9) < 7);
         ctlRedir   = ($urandom_range(99) < 8);
         ctlRedirPc = $urandom;
         ctlRst     = ($urandom_range(199) == 0);
         applyStimulus();
      end
      ctlRst = 1'b0; ctlRedir = 1'b0; ctlReady = 1'b1;
      gntMode = 1; latLo = 1; latHi = 1; spurious = 1'b0;
   endtask

   initial begin
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_on_grant();
      test_redirect_in_wait();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
